// File: rtl/chkmon_pkg.sv
// ============================================================================
// Module      : chkmon_pkg
// Description : Shared types and helpers for the checkbits sequence monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chkmon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        PASS_ST = 3'd3,
        FAIL_ST = 3'd4
    } state_t;

    localparam logic [15:0] C_START_VALUE = 16'hAB40;

    // Operands are zero-extended by the caller; buses up to 64 bits are supported.
    function automatic logic masked_eq(input logic [63:0] a,
                                       input logic [63:0] b,
                                       input logic [63:0] m);
        return ((a ^ b) & m) == 64'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chkmon_stable_filter.sv
// ============================================================================
// Module      : chkmon_stable_filter
// Description : Holds the last bus sample and a saturating run-length counter;
//               flags a value as stable and marks the first stable cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chkmon_stable_filter #(
    parameter int DATA_W        = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_stable_val,
    output logic              o_stable_vld,
    output logic              o_stable_rise
);

    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   c_stable = CW'(STABLE_CYCLES);

    logic [DATA_W-1:0] r_sample;
    logic [CW-1:0]     r_count;
    logic              r_rise;
    logic              w_changed;
    logic [CW-1:0]     w_count_nxt;

    assign w_changed = (i_data != r_sample);

    always_comb begin
        w_count_nxt = r_count;
        if (w_changed)
            w_count_nxt = CW'(1);
        else if (r_count != c_stable)
            w_count_nxt = r_count + CW'(1);
    end

    // Rise is computed from the next count so it lines up with the first valid
    // cycle; a change with STABLE_CYCLES=1 is still seen as a fresh rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_count  <= '0;
            r_rise   <= 1'b0;
        end else begin
            r_sample <= i_data;
            r_count  <= w_count_nxt;
            r_rise   <= (w_count_nxt == c_stable) && (w_changed || (r_count != c_stable));
        end
    end

    assign o_stable_val  = r_sample;
    assign o_stable_vld  = (r_count == c_stable);
    assign o_stable_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/checkbits_seq_monitor.sv
// ============================================================================
// Module      : checkbits_seq_monitor
// Description : Checkpoint-sequence monitor for the firmware checkbits bus with
//               programmable table, timeout and sticky pass/fail status.
//               Optional macro CHKMON_STRICT_EN fails on unexpected values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module checkbits_seq_monitor
    import chkmon_pkg::*;
#(
    parameter int                    DATA_W        = 16,
    parameter int                    DEPTH         = 32,
    parameter int                    STABLE_CYCLES = 4,
    parameter int                    TIMEOUT_W     = 24,
    parameter logic [DATA_W-1:0]     START_VALUE   = C_START_VALUE
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [DATA_W-1:0]          mon_in,
    input  logic [DATA_W-1:0]          cmp_mask,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_addr,
    input  logic [DATA_W-1:0]          exp_wdata,
    input  logic [$clog2(DEPTH):0]     num_exp,
    input  logic [TIMEOUT_W-1:0]       timeout_lim,
    input  logic                       start,
    output logic                       busy,
    output logic                       match_pulse,
    output logic [$clog2(DEPTH)-1:0]   match_idx,
    output logic                       pass,
    output logic                       fail,
    output logic [$clog2(DEPTH)-1:0]   fail_idx
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             NW      = AW + 1;
    localparam logic [NW-1:0]  c_depth = NW'(DEPTH);

    logic [DATA_W-1:0]    r_table [DEPTH];
    state_t               r_state;
    logic [AW-1:0]        r_idx;
    logic [AW-1:0]        r_last_idx;
    logic [TIMEOUT_W-1:0] r_timer;
    logic                 r_busy;
    logic                 r_match_pulse;
    logic [AW-1:0]        r_match_idx;
    logic                 r_pass;
    logic                 r_fail;
    logic [AW-1:0]        r_fail_idx;

    logic [DATA_W-1:0]    w_stable_val;
    logic                 w_stable_vld;
    logic                 w_stable_rise;
    logic [DATA_W-1:0]    w_exp_cur;
    logic                 w_hit_start;
    logic                 w_hit_cur;
    logic                 w_timeout;
    logic                 w_strict_bad;
    logic [AW-1:0]        w_last_idx;

    chkmon_stable_filter #(
        .DATA_W        (DATA_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk           (wb_clk_i),
        .rst           (wb_rst_i),
        .i_data        (mon_in),
        .o_stable_val  (w_stable_val),
        .o_stable_vld  (w_stable_vld),
        .o_stable_rise (w_stable_rise)
    );

    // Table is deliberately not reset so firmware can preload it before reset release.
    always_ff @(posedge wb_clk_i) begin
        if (exp_we)
            r_table[exp_addr] <= exp_wdata;
    end

    always_comb begin
        w_last_idx = AW'(num_exp - NW'(1));
        if (num_exp == '0)
            w_last_idx = '0;
        else if (num_exp > c_depth)
            w_last_idx = AW'(DEPTH - 1);
    end

    assign w_exp_cur   = r_table[r_idx];
    assign w_hit_start = w_stable_vld &&
                         masked_eq(64'(w_stable_val), 64'(START_VALUE), 64'(cmp_mask));
    assign w_hit_cur   = w_stable_rise &&
                         masked_eq(64'(w_stable_val), 64'(w_exp_cur), 64'(cmp_mask));
    assign w_timeout   = (timeout_lim != '0) && (r_timer == timeout_lim - TIMEOUT_W'(1));

`ifdef CHKMON_STRICT_EN
    logic [DATA_W-1:0] w_exp_prev;
    assign w_exp_prev   = (r_idx == '0) ? START_VALUE : r_table[r_idx - AW'(1)];
    assign w_strict_bad = w_stable_rise && !w_hit_cur &&
                          !masked_eq(64'(w_stable_val), 64'(w_exp_prev), 64'(cmp_mask));
`else
    assign w_strict_bad = 1'b0;
`endif

    // Priority: start > accepted step > strict violation > timeout.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_last_idx    <= '0;
            r_timer       <= '0;
            r_busy        <= 1'b0;
            r_match_pulse <= 1'b0;
            r_match_idx   <= '0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_fail_idx    <= '0;
        end else begin
            r_match_pulse <= 1'b0;
            if (start) begin
                r_state    <= ARMED;
                r_busy     <= 1'b1;
                r_pass     <= 1'b0;
                r_fail     <= 1'b0;
                r_fail_idx <= '0;
                r_idx      <= '0;
                r_timer    <= '0;
                r_last_idx <= w_last_idx;
            end else begin
                case (r_state)
                    ARMED: begin
                        if (w_hit_start) begin
                            r_state <= RUN;
                            r_timer <= '0;
                        end else if (w_timeout) begin
                            r_state    <= FAIL_ST;
                            r_busy     <= 1'b0;
                            r_fail     <= 1'b1;
                            r_fail_idx <= '0;
                        end else begin
                            r_timer <= r_timer + TIMEOUT_W'(1);
                        end
                    end
                    RUN: begin
                        if (w_hit_cur) begin
                            r_match_pulse <= 1'b1;
                            r_match_idx   <= r_idx;
                            if (r_idx == r_last_idx) begin
                                r_state <= PASS_ST;
                                r_busy  <= 1'b0;
                                r_pass  <= 1'b1;
                            end else begin
                                r_idx   <= r_idx + AW'(1);
                                r_timer <= '0;
                            end
                        end else if (w_strict_bad || w_timeout) begin
                            r_state    <= FAIL_ST;
                            r_busy     <= 1'b0;
                            r_fail     <= 1'b1;
                            r_fail_idx <= r_idx;
                        end else begin
                            r_timer <= r_timer + TIMEOUT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign match_pulse = r_match_pulse;
    assign match_idx   = r_match_idx;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign fail_idx    = r_fail_idx;

endmodule

`default_nettype wire

// File: tb/tb_checkbits_seq_monitor.sv
// ============================================================================
// Module      : tb_checkbits_seq_monitor
// Description : Directed and randomized self-checking bench for the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_checkbits_seq_monitor;

`ifdef CHKMON_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mon_in;
    logic [15:0] cmp_mask;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic [5:0]  num_exp;
    logic [23:0] timeout_lim;
    logic        start;
    logic        busy;
    logic        match_pulse;
    logic [4:0]  match_idx;
    logic        pass;
    logic        fail;
    logic [4:0]  fail_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_q[$];

    always #5 clk = ~clk;

    checkbits_seq_monitor dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .mon_in      (mon_in),
        .cmp_mask    (cmp_mask),
        .exp_we      (exp_we),
        .exp_addr    (exp_addr),
        .exp_wdata   (exp_wdata),
        .num_exp     (num_exp),
        .timeout_lim (timeout_lim),
        .start       (start),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_idx   (match_idx),
        .pass        (pass),
        .fail        (fail),
        .fail_idx    (fail_idx)
    );

    always @(negedge clk) begin
        if (match_pulse)
            pulse_q.push_back(int'(match_idx));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] v, input int n);
        mon_in = v;
        cyc(n);
    endtask

    task automatic write_exp(input int addr, input logic [15:0] v);
        exp_we    = 1'b1;
        exp_addr  = 5'(addr);
        exp_wdata = v;
        cyc(1);
        exp_we    = 1'b0;
    endtask

    task automatic arm(input int n, input int lim, input logic [15:0] m);
        num_exp     = 6'(n);
        timeout_lim = 24'(lim);
        cmp_mask    = m;
        start       = 1'b1;
        cyc(1);
        start       = 1'b0;
    endtask

    initial begin
        logic [15:0] tab[$];
        logic [15:0] v;
        logic [15:0] last;
        int          exp_q[$];
        int          n;
        int          m_idx;
        int          hold;

        rst = 1'b1; mon_in = '0; cmp_mask = '1; exp_we = 1'b0; exp_addr = '0;
        exp_wdata = '0; num_exp = '0; timeout_lim = '0; start = 1'b0;
        cyc(3);
        check("rst_busy", busy, 0);
        check("rst_match_pulse", match_pulse, 0);
        check("rst_match_idx", match_idx, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_idx", fail_idx, 0);
        rst = 1'b0;
        cyc(2);

        // Sequence pass
        write_exp(0, 16'h003E); write_exp(1, 16'h0044);
        write_exp(2, 16'h004A); write_exp(3, 16'h0050);
        arm(4, 1000, 16'hFFFF);
        pulse_q.delete();
        check("seq_busy_armed", busy, 1);
        drive(16'hAB40, 10);
        drive(16'h003E, 10); drive(16'h0044, 10);
        drive(16'h004A, 10); drive(16'h0050, 10);
        cyc(2);
        check("seq_pulses", pulse_q.size(), 4);
        for (int i = 0; i < 4 && i < pulse_q.size(); i++)
            check("seq_idx", pulse_q[i], i);
        check("seq_pass", pass, 1);
        check("seq_fail", fail, 0);
        check("seq_busy_done", busy, 0);

        // Glitch filter: a 3-cycle value is never accepted
        write_exp(0, 16'h003E); write_exp(1, 16'h0044);
        arm(2, 1000, 16'hFFFF);
        drive(16'hAB40, 10);
        pulse_q.delete();
        drive(16'h003E, 3); drive(16'h0044, 10);
        check("glitch_pulses", pulse_q.size(), 0);
        check("glitch_fail", fail, 0);
        check("glitch_busy", busy, 1);

        // Timeout exactly 50 cycles after RUN entry
        write_exp(0, 16'h003E);
        arm(1, 50, 16'hFFFF);
        drive(16'hAB40, STABLE + 1);
        check("to_busy_run", busy, 1);
        drive(16'h0000, 49);
        check("to_fail_early", fail, 0);
        cyc(1);
        check("to_fail", fail, 1);
        check("to_fail_idx", fail_idx, 0);
        check("to_busy", busy, 0);

        // Repeated entries need a bus change in between
        write_exp(0, 16'h0000); write_exp(1, 16'h0000);
        arm(2, 0, 16'hFFFF);
        drive(16'hAB40, 10);
        pulse_q.delete();
        drive(16'h0000, 20);
        check("rep_one_match", pulse_q.size(), 1);
        check("rep_no_pass", pass, 0);
        drive(16'h1234, 10); drive(16'h0000, 10);
        check("rep_two_match", pulse_q.size(), 2);
        if (pulse_q.size() > 1)
            check("rep_idx1", pulse_q[1], 1);
        check("rep_pass", pass, 1);

        // Masking, restart from PASS, reset in RUN
        write_exp(0, 16'h1150);
        arm(1, 0, 16'h00FF);
        drive(16'hAB40, 10); drive(16'h2250, 10);
        check("mask_pass", pass, 1);
        start = 1'b1; cyc(1); start = 1'b0;
        check("restart_pass_clr", pass, 0);
        check("restart_busy", busy, 1);
        drive(16'h3340, 10);
        check("mask_start_run", busy, 1);
        rst = 1'b1; cyc(1);
        check("midrst_busy", busy, 0);
        check("midrst_pass", pass, 0);
        check("midrst_fail", fail, 0);
        check("midrst_match_pulse", match_pulse, 0);
        check("midrst_match_idx", match_idx, 0);
        check("midrst_fail_idx", fail_idx, 0);
        rst = 1'b0; cyc(1);

        // Strict mode: out-of-order value at step 1
        write_exp(0, 16'h0010); write_exp(1, 16'h0020);
        arm(2, 0, 16'hFFFF);
        drive(16'hAB40, 10); drive(16'h0010, 10); drive(16'h0099, 10);
        check("strict_fail", fail, 32'(STRICT));
        check("strict_fail_idx", fail_idx, STRICT ? 1 : 0);
        check("strict_busy", busy, 32'(!STRICT));

        // num_exp=0 acts as 1, and a later num_exp change is ignored
        write_exp(0, 16'h0055); write_exp(1, 16'h0066);
        arm(0, 0, 16'hFFFF);
        num_exp = 6'd2;
        drive(16'hAB40, 10); drive(16'h0055, 10);
        check("nexp0_pass", pass, 1);

        // Rewrite of the entry currently compared
        write_exp(0, 16'h0077);
        arm(1, 0, 16'hFFFF);
        drive(16'hAB40, 10);
        write_exp(0, 16'h0088);
        drive(16'h0088, 10);
        check("live_write_pass", pass, 1);

        // Randomized sequences against a segment-level reference model
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(2, 6);
            tab.delete();
            for (int i = 0; i < n; i++) begin
                v = 16'($urandom);
                if (v == 16'hAB40 || (i > 0 && v == tab[i-1]))
                    v = v ^ 16'h0101;
                tab.push_back(v);
                write_exp(i, v);
            end
            arm(n, 0, 16'hFFFF);
            drive(16'hAB40, 10);
            pulse_q.delete();
            exp_q.delete();
            last  = 16'hAB40;
            m_idx = 0;
            for (int s = 0; s < 3 * n && m_idx < n; s++) begin
                if (!STRICT && $urandom_range(0, 1) == 1)
                    v = 16'($urandom);
                else
                    v = tab[m_idx];
                if (v == last)
                    v = last ^ 16'h0100;
                hold = STRICT ? $urandom_range(STABLE, 10) : $urandom_range(1, 10);
                drive(v, hold);
                // A segment held for STABLE cycles is one newly stable value.
                if (hold >= STABLE && v == tab[m_idx]) begin
                    exp_q.push_back(m_idx);
                    m_idx++;
                end
                last = v;
            end
            while (m_idx < n) begin
                if (tab[m_idx] == last) begin
                    last = last ^ 16'h0100;
                    drive(last, 6);
                end
                drive(tab[m_idx], 8);
                exp_q.push_back(m_idx);
                last = tab[m_idx];
                m_idx++;
            end
            cyc(3);
            check("rnd_pulses", pulse_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < pulse_q.size(); i++)
                check("rnd_idx", pulse_q[i], exp_q[i]);
            check("rnd_pass", pass, 1);
            check("rnd_fail", fail, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/checkbits_seq_monitor.md
Name: checkbits_seq_monitor

Overview:
Synthesizable checkpoint-sequence monitor for the 16-bit mprj_io[31:16] checkbits bus driven by firmware during Caravel soak and selftest runs. It is the parametrised successor of the bench-side wait/display chain, and can sit either in the user project area or in a testbench harness.
- Firmware-programmable table of expected values.
- Stability filtering, per-step timeout, start-marker detection.
- Sticky PASS/FAIL status, exposed to the LA bus and a GPIO status pin.

Parameters:
DATA_W, 16, width of the monitored bus and of expected entries
DEPTH, 32, expected-table entries (power of 2, >=2)
STABLE_CYCLES, 4, consecutive identical samples required before a value counts as seen (>=1)
TIMEOUT_W, 24, width of the per-step timeout counter
START_VALUE, 16'hAB40, start marker that arms sequence checking

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
mon_in  in  DATA_W  monitored bus (checkbits)
cmp_mask  in  DATA_W  1 = bit compared; 0 = ignored
exp_we  in  1  table write strobe
exp_addr  in  $clog2(DEPTH)  table write address
exp_wdata  in  DATA_W  table write data
num_exp  in  $clog2(DEPTH)+1  number of valid entries, 1..DEPTH
timeout_lim  in  TIMEOUT_W  cycles allowed per step; 0 = timeout disabled
start  in  1  one-cycle arm pulse
busy  out  1  high in ARMED or RUN
match_pulse  out  1  one-cycle pulse on each accepted step
match_idx  out  $clog2(DEPTH)  index of the last accepted step
pass  out  1  sticky: all num_exp entries matched
fail  out  1  sticky: timeout, or strict violation
fail_idx  out  $clog2(DEPTH)  step index at which the failure occurred

Behaviour:
- Reset values: every output is 0. State = IDLE, step index = 0, timer = 0, filter count = 0. Table contents are not reset.
- Stability filter:
  - Holds the previous sample and a count that saturates at STABLE_CYCLES.
  - stable_vld is high while the count equals STABLE_CYCLES.
  - Any change in mon_in (full width, unmasked) reloads count to 1.
- FSM:
  - IDLE: on start -> ARMED; clear pass, fail, index and timer.
  - ARMED: when stable_vld and (stable_val & mask) == (START_VALUE & mask) -> RUN; timer cleared.
  - RUN: when stable_vld and masked stable_val == masked exp[idx], pulse match_pulse and set match_idx = idx.
    - If idx == num_exp-1 -> PASS_ST, set pass.
    - Otherwise idx+1, timer cleared.
  - PASS_ST / FAIL_ST: hold until start (-> ARMED, status cleared) or reset.
- Edge-triggered acceptance: a step is accepted only on the first cycle stable_vld rises for a given value.
  - A value that stays on the bus cannot match two consecutive identical table entries.
  - Consecutive equal entries require the bus to change in between.
- Timeout:
  - The timer increments every cycle in ARMED and RUN.
  - When timeout_lim != 0 and timer == timeout_lim-1 with no match that cycle: -> FAIL_ST, fail = 1, fail_idx = idx. In ARMED, fail_idx = 0.
  - If a match and the timeout limit coincide in the same cycle, the match wins.
- Boundary conditions:
  - num_exp = 0 is treated as 1. Values > DEPTH are clamped to DEPTH.
  - num_exp is sampled at start; later changes are ignored until the next start.
  - exp_we during RUN to an entry >= idx takes effect the cycle after the write. Writes to the currently compared entry are allowed.
  - start while busy restarts the sequence (-> ARMED, status cleared).
  - wb_rst_i mid-run aborts to IDLE; pass and fail are cleared.
- Latency: mon_in change to match_pulse = STABLE_CYCLES+1 cycles (registered compare).

Optional Feature:
CHKMON_STRICT_EN
- Defined: in RUN, a newly stable value that matches neither exp[idx] nor exp[idx-1] (at idx = 0, the START_VALUE) -> FAIL_ST, fail_idx = idx. This catches out-of-order or corrupt checkpoints.
- Undefined: unexpected stable values are ignored, matching the original wait-until semantics.

Decomposition:
- Package chkmon_pkg:
  - state enum {IDLE, ARMED, RUN, PASS_ST, FAIL_ST}
  - default START_VALUE constant
  - masked-compare function
- Sub-module chkmon_stable_filter: the sample register, saturating counter, and stable_vld/stable_rise outputs, parametrised by DATA_W and STABLE_CYCLES.
- The table is a plain register array in the top module.

Test Plan:
1. Sequence pass:
   - Load table {003E, 0044, 004A, 0050}, num_exp=4, mask=FFFF, timeout_lim=1000, start.
   - Drive AB40 then each value, each held 10 cycles.
   - Expect 4 match_pulses with idx 0..3, then pass=1, fail=0, busy=0.
2. Glitch filter:
   - Drive 003E for 3 cycles, then 0044 for 10 cycles, with STABLE_CYCLES=4.
   - Expect no match for 003E; the monitor stays at idx 0.
   - fail is 0 as long as the timeout is not reached.
3. Timeout:
   - timeout_lim=50; after AB40, hold 0000 with the table expecting 003E.
   - Expect fail=1 exactly 50 cycles after the RUN entry, with fail_idx=0.
4. Repeated entries:
   - Table {0000, 0000}: holding 0000 yields a single match.
   - Toggling to 1234 and back yields the second match, then pass.
5. Masking and restart:
   - mask=00FF, table {1150}, bus 2250 -> match, pass.
   - Then assert start mid-PASS -> pass clears, busy=1.
   - Assert wb_rst_i in RUN -> all outputs 0 the next cycle.
6. Strict mode (CHKMON_STRICT_EN):
   - Table {0010, 0020}; drive AB40, 0010, 0099.
   - Expect fail=1 with fail_idx=1.
   - The same stimulus without the macro gives no fail.
